// File: rtl/keypad_scan_ctrl.sv
// Purpose: 4x4 matrix keypad scanner. It drives one row low at a time, synchronises and debounces the columns, and emits one hex code per press.
// Latency: about 2 sync + SETTLE_CYCLES + DEBOUNCE_CYCLES + 2 clk from a key going down to key_valid.
// Backpressure: key_valid holds the code until key_ready. A new press overwrites a code that has not been consumed.
// Optional: define KEYPAD_REPEAT_EN to re-issue a held key (REPEAT_DELAY first, then every REPEAT_PERIOD).
module keypad_scan_ctrl #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] column,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESS, HOLD} state_t;

    localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LIM = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      row_q, row_d;
    logic [3:0]      pattern_q, pattern_d;
    logic [3:0]      key_q, key_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;
    logic [3:0]      sync1_q, col_s_q;
    logic            load;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]   rpt_q, rpt_d;
    logic            rpt_first_q, rpt_first_d;
    logic [RW-1:0]   rpt_last;
`endif

    // Row index and lowest low column select one of 16 codes.
    function automatic logic [3:0] key_map(input logic [3:0] r, input logic [3:0] c);
        logic [1:0] ri;
        logic [1:0] ci;
        logic [3:0] code;
        case (r)
            4'b1110: ri = 2'd0;
            4'b1101: ri = 2'd1;
            4'b1011: ri = 2'd2;
            default: ri = 2'd3;
        endcase
        if (!c[0])      ci = 2'd0;
        else if (!c[1]) ci = 2'd1;
        else if (!c[2]) ci = 2'd2;
        else            ci = 2'd3;
        case ({ri, ci})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchroniser for the asynchronous column pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b1111;
            col_s_q <= 4'b1111;
        end else begin
            sync1_q <= column;
            col_s_q <= sync1_q;
        end
    end

    // Next-state logic for scan/debounce/hold, plus the key handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        pattern_d   = pattern_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        key_held_d  = key_held_q;
        load        = 1'b0;

        if (key_valid_q && key_ready) key_valid_d = 1'b0;

        case (state_q)
            SCAN: begin
                if (cnt_q < SETTLE_LIM) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (col_s_q == 4'b1111) begin
                    row_d = {row_q[2:0], row_q[3]};
                    cnt_d = '0;
                end else begin
                    pattern_d = col_s_q;
                    cnt_d     = '0;
                    state_d   = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (col_s_q != pattern_q) begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end else if (cnt_q >= DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = PRESS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESS: begin
                load       = 1'b1;
                key_held_d = 1'b1;
                cnt_d      = '0;
                state_d    = HOLD;
            end
            default: begin
                // HOLD: any low column restarts the release count.
                if (col_s_q != 4'b1111) begin
                    cnt_d = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    key_held_d = 1'b0;
                    row_d      = {row_q[2:0], row_q[3]};
                    cnt_d      = '0;
                    state_d    = SCAN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

`ifdef KEYPAD_REPEAT_EN
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
        rpt_last    = rpt_first_q ? PERIOD_LAST : DELAY_LAST;
        if (state_q != HOLD) begin
            rpt_d       = '0;
            rpt_first_d = 1'b0;
        end else if ((col_s_q == pattern_q) && (rpt_q >= rpt_last)) begin
            load        = 1'b1;
            rpt_d       = '0;
            rpt_first_d = 1'b1;
        end else if (rpt_q < rpt_last) begin
            rpt_d = rpt_q + RW'(1);
        end
`endif

        if (load) begin
            key_d       = key_map(row_q, pattern_q);
            key_valid_d = 1'b1;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            row_q       <= 4'b1110;
            pattern_q   <= 4'b1111;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            pattern_q   <= pattern_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat timer. It only runs in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    assign row       = row_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Purpose: directed bench for keypad_scan_ctrl with a behavioural 4x4 key matrix.
// Latency: the expected cycle counts below are derived by hand from the scan/debounce timing.
// Backpressure: exercises key_ready low (hold and overwrite) and key_ready high (single pulse).
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] column;
    logic [3:0] row;
    logic [3:0] key;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;

    // Behavioural keypad: one key at (pr, pmask) pulls columns low while its row is driven.
    logic       pressed;
    logic [1:0] pr;
    logic [3:0] pmask;
    logic [3:0] sel_row;

    int checks = 0;
    int errors = 0;
    int acc    = 0;

    assign sel_row = ~(4'b0001 << pr);
    assign column  = (pressed && (row == sel_row)) ? pmask : 4'b1111;

    keypad_scan_ctrl #(
        .SETTLE_CYCLES  (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .column   (column),
        .row      (row),
        .key      (key),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Count accepted handshakes.
    always @(posedge clk) if (!rst && key_valid && key_ready) acc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int maxc);
        for (int i = 0; i < maxc && key_valid !== 1'b1; i++) tick();
    endtask

    task automatic wait_held(input logic lvl, input int maxc);
        for (int i = 0; i < maxc && key_held !== lvl; i++) tick();
    endtask

    // Release the key and wait until the release has been debounced.
    task automatic release_key(input string tag);
        pressed = 1'b0;
        wait_held(1'b0, 40);
        check_eq(tag, 32'(key_held), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rows [5];
        int         times [8];
        int         n;
        rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        rst = 1'b1; key_ready = 1'b0; pressed = 1'b0; pr = 2'd0; pmask = 4'b1111;
        @(negedge clk);
        tick();
        check_eq("rst_row",   32'(row), 'hE);
        check_eq("rst_key",   32'(key), 'h0);
        check_eq("rst_valid", 32'(key_valid), 0);
        check_eq("rst_held",  32'(key_held), 0);

        // 1: idle scan, three clocks per row
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check_eq($sformatf("scan_row%0d", i), 32'(row), 32'(rows[i / 3]));
            tick();
        end
        check_eq("scan_valid", 32'(key_valid), 0);

        // 2: key 8 (row 2, column 1), ready high -> one pulse; release takes 2 sync + 4 debounce clocks
        acc = 0; key_ready = 1'b1; pr = 2'd2; pmask = 4'b1101; pressed = 1'b1;
        wait_valid(60);
        check_eq("k8_valid", 32'(key_valid), 1);
        check_eq("k8_key",   32'(key), 'h8);
        check_eq("k8_held",  32'(key_held), 1);
        for (int i = 0; i < 10; i++) tick();
        pressed = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_eq("k8_held_late", 32'(key_held), 1);
        tick();
        check_eq("k8_held_drop", 32'(key_held), 0);
        check_eq("k8_pulses", 32'(acc), 1);

        // 3: bouncing key 1 is rejected; a steady press is then accepted
        acc = 0; pr = 2'd0; pmask = 4'b1110;
        for (int i = 0; i < 20; i++) begin
            pressed = 1'b1; tick(); tick();
            pressed = 1'b0; tick();
        end
        check_eq("bounce_pulses", 32'(acc), 0);
        pressed = 1'b1;
        wait_valid(60);
        check_eq("k1_valid", 32'(key_valid), 1);
        check_eq("k1_key",   32'(key), 'h1);
        release_key("k1_release");

        // 3b: exact press latency from reset with key 1 already down
        rst = 1'b1; pressed = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("lat_valid_pre", 32'(key_valid), 0);
        tick();
        check_eq("lat_valid", 32'(key_valid), 1);
        check_eq("lat_key",   32'(key), 'h1);
        tick();
        check_eq("lat_consumed", 32'(key_valid), 0);
        release_key("lat_release");

        // 4: row 3 with columns 0 and 2 low -> lowest column wins, code E; ready low holds it
        key_ready = 1'b0; pr = 2'd3; pmask = 4'b1010; pressed = 1'b1;
        wait_valid(60);
        check_eq("kE_key", 32'(key), 'hE);
        release_key("kE_release");
        check_eq("kE_valid_kept", 32'(key_valid), 1);
        check_eq("kE_key_kept",   32'(key), 'hE);
        // An unconsumed code is overwritten by the next press (key 2).
        pr = 2'd0; pmask = 4'b1101; pressed = 1'b1;
        wait_held(1'b1, 60);
        check_eq("ovw_key",   32'(key), 'h2);
        check_eq("ovw_valid", 32'(key_valid), 1);
        release_key("ovw_release");
        key_ready = 1'b1;
        tick();
        check_eq("ack_valid", 32'(key_valid), 0);
        check_eq("ack_key",   32'(key), 'h2);
        tick();
        check_eq("idle_ready", 32'(key_valid), 0);

        // 5: key 5, reset pulsed mid-debounce, then the press is rescanned
        rst = 1'b1; pr = 2'd1; pmask = 4'b1101; pressed = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("k5_row_pre", 32'(row), 'hD);
        check_eq("k5_valid_pre", 32'(key_valid), 0);
        rst = 1'b1;
        #1;
        check_eq("k5_rst_row",   32'(row), 'hE);
        check_eq("k5_rst_valid", 32'(key_valid), 0);
        check_eq("k5_rst_held",  32'(key_held), 0);
        tick();
        rst = 1'b0;
        wait_valid(60);
        check_eq("k5_valid", 32'(key_valid), 1);
        check_eq("k5_key",   32'(key), 'h5);
        release_key("k5_release");

`ifdef KEYPAD_REPEAT_EN
        // 6: key D held -> pulses at PRESS, +20, +28, +36 ...
        rst = 1'b1; pr = 2'd3; pmask = 4'b0111; pressed = 1'b1; key_ready = 1'b1; tick(); rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (key_valid && n < 8) begin
                times[n] = i;
                n++;
            end
        end
        check_eq("rpt_count", 32'(n), 6);
        check_eq("rpt_first", 32'(times[0]), 17);
        check_eq("rpt_gap0", 32'(times[1] - times[0]), 20);
        check_eq("rpt_gap1", 32'(times[2] - times[1]), 8);
        check_eq("rpt_gap2", 32'(times[3] - times[2]), 8);
        check_eq("rpt_key", 32'(key), 'hD);
        release_key("rpt_release");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
